// File: rtl/rep_code_tx.sv
// rep_code_tx: repetition-code serial transmitter.
// A parallel word is accepted over a valid/ready handshake and sent MSB-first.
// Every data bit is repeated as REP identical chips, so a majority voter on the
// receive side can correct one corrupted chip per bit. The chip stream leaves
// over a valid/ready handshake with first/last framing flags.
module rep_code_tx #(
  parameter int DATA_W = 8,
  parameter int REP    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_first,
  output logic              tx_last,
  output logic              busy
);

  // Counter widths. A one-bit counter is kept even when only value 0 is
  // reachable (REP=1 or DATA_W=1) so that no zero-width vector appears.
  localparam int CHIP_W = (REP > 1) ? $clog2(REP) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CHIP_W-1:0] CHIP_MAX = CHIP_W'(REP - 1);
  localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_W - 1);

  // Parameter legality: an even chip count makes majority voting ambiguous,
  // and the counters are sized for words of at most 32 bits.
  generate
    if ((REP < 1) || ((REP % 2) == 0)) begin : g_bad_rep
      $error("rep_code_tx: REP must be odd and at least 1");
    end
    if ((DATA_W < 1) || (DATA_W > 32)) begin : g_bad_width
      $error("rep_code_tx: DATA_W must be in the range 1..32");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_shift;
  logic [CHIP_W-1:0]   r_chip;
  logic [BIT_W-1:0]    r_bit;

  logic                w_sending;
  logic                w_xfer;
  logic                w_chip_end;
  logic                w_frame_end;
  logic                w_accept;

  // Decode of the current chip position and the two handshakes.
  always_comb begin
    w_sending   = (r_state == ST_SEND);
    w_xfer      = w_sending && tx_ready;
    w_chip_end  = (r_chip == CHIP_MAX);
    w_frame_end = w_chip_end && (r_bit == '0);
    // The last-chip transfer frees the block in the same cycle, which is what
    // lets the next word follow with no idle chip slot in between.
    in_ready    = !rst && (!w_sending || (w_xfer && w_frame_end));
    w_accept    = in_valid && in_ready;
  end

  // Next-state logic: a frame ends on its last-chip transfer unless a new
  // word is taken in that same cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_xfer && w_frame_end) begin
          w_state_next = w_accept ? ST_SEND : ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: load on accept, otherwise advance one chip per transfer and
  // move to the next data bit after REP chips. Stalls hold everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_chip  <= '0;
      r_bit   <= '0;
    end else if (w_accept) begin
      r_shift <= in_data;
      r_chip  <= '0;
      r_bit   <= BIT_MAX;
    end else if (w_xfer) begin
      if (!w_chip_end) begin
        r_chip <= r_chip + CHIP_W'(1);
      end else begin
        r_chip  <= '0;
        r_shift <= r_shift << 1;
        r_bit   <= r_bit - BIT_W'(1);
      end
    end
  end

  // Chip-side outputs decode registered state only; nothing from in_data
  // reaches tx_bit without passing through the shift register. Gating with
  // the SEND state keeps every output at 0 while idle.
  always_comb begin
    tx_valid = w_sending;
    busy     = w_sending;
    tx_bit   = w_sending && r_shift[DATA_W-1];
    tx_first = w_sending && (r_bit == BIT_MAX) && (r_chip == '0);
    tx_last  = w_sending && w_frame_end;
  end

endmodule

// File: tb/tb_rep_code_tx.sv
// Directed testbench for rep_code_tx: default 8x3 instance plus a 4x5 instance
// used with a 5-input majority decoder.
module tb_rep_code_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] in_data  = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx_bit;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       tx_first;
  logic       tx_last;
  logic       busy;

  logic [3:0] in_data4  = '0;
  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic       tx_bit4;
  logic       tx_valid4;
  logic       tx_ready4 = 1'b0;
  logic       tx_first4;
  logic       tx_last4;
  logic       busy4;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  rep_code_tx #(.DATA_W(8), .REP(3)) u_dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_first(tx_first), .tx_last(tx_last), .busy(busy)
  );

  rep_code_tx #(.DATA_W(4), .REP(5)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .tx_bit(tx_bit4), .tx_valid(tx_valid4), .tx_ready(tx_ready4),
    .tx_first(tx_first4), .tx_last(tx_last4), .busy(busy4)
  );

  // Drives words (then optional unwanted words) and records every chip
  // transfer of the 8x3 instance. Starts and ends one time unit after an edge.
  task automatic run_frames(
    input  logic [7:0]  w0,
    input  logic [7:0]  w1,
    input  int          nwords,
    input  int          pattern,
    input  int          max_cycles,
    input  int          junk_from,
    input  int          junk_to,
    output logic [63:0] chips,
    output int          n,
    output logic [63:0] firsts,
    output logic [63:0] lasts,
    output int          busy_n,
    output int          stall_err,
    output int          junk_acc,
    output int          acc_on_last
  );
    int   widx = 0;
    logic prev_stall = 1'b0;
    logic prev_bit = 1'b0;
    logic prev_first = 1'b0;
    logic prev_last = 1'b0;
    chips = '0; firsts = '0; lasts = '0;
    n = 0; busy_n = 0; stall_err = 0; junk_acc = 0; acc_on_last = 0;
    for (int c = 0; c < max_cycles; c++) begin
      tx_ready = (pattern == 0) ? 1'b1 : ((c % 3) == 0);
      if (widx < nwords) begin
        in_valid = 1'b1;
        in_data  = (widx == 0) ? w0 : w1;
      end else if (c >= junk_from && c <= junk_to) begin
        in_valid = 1'b1;
        in_data  = 8'h3C;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        if (!tx_valid || tx_bit !== prev_bit || tx_first !== prev_first ||
            tx_last !== prev_last) begin
          stall_err++;
        end
      end
      if (busy) busy_n++;
      if (in_valid && in_ready) begin
        if (widx < nwords) begin
          if (widx == 1 && tx_valid && tx_ready && tx_last) acc_on_last++;
          widx++;
        end else begin
          junk_acc++;
        end
      end
      if (tx_valid && tx_ready) begin
        chips  = {chips[62:0], tx_bit};
        firsts = {firsts[62:0], tx_first};
        lasts  = {lasts[62:0], tx_last};
        n++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_bit   = tx_bit;
      prev_first = tx_first;
      prev_last  = tx_last;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({tx_bit, tx_valid, tx_first, tx_last, busy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 00000", {tx_bit, tx_valid, tx_first, tx_last, busy});
    end
    checks++;
    if (in_ready !== 1'b0 || in_ready4 !== 1'b0) begin
      fails++;
      $display("FAIL reset_in_ready: got %b/%b expected 0/0", in_ready, in_ready4);
    end
    checks++;
    if ({tx_valid4, busy4, tx_bit4} !== 3'b0) begin
      fails++;
      $display("FAIL reset_outputs4: got %b expected 000", {tx_valid4, busy4, tx_bit4});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: in_ready=%b tx_valid=%b expected 1/0", in_ready, tx_valid);
    end
    @(posedge clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [63:0] chips, firsts, lasts;
    int n, busy_n, stall_err, junk_acc, acc_on_last;
    logic [23:0] exp_chips;
    exp_chips = 24'b111000111000000111000111;
    run_frames(8'hA5, 8'h00, 1, 0, 32, -1, -1, chips, n, firsts, lasts,
               busy_n, stall_err, junk_acc, acc_on_last);
    checks++;
    if (n !== 24) begin fails++; $display("FAIL single_count: got %0d expected 24", n); end
    checks++;
    if (chips[23:0] !== exp_chips) begin
      fails++; $display("FAIL single_chips: got %b expected %b", chips[23:0], exp_chips);
    end
    checks++;
    if (firsts[23:0] !== 24'h800000 || lasts[23:0] !== 24'h000001) begin
      fails++; $display("FAIL single_flags: first %h last %h expected 800000 000001", firsts[23:0], lasts[23:0]);
    end
    checks++;
    if (busy_n !== 24) begin fails++; $display("FAIL single_busy: got %0d expected 24", busy_n); end
    checks++;
    if (in_ready !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL single_idle: in_ready=%b tx_valid=%b busy=%b expected 1 0 0", in_ready, tx_valid, busy);
    end
    $display("test_single: A5 chips=%b", chips[23:0]);
  endtask

  task automatic test_backpressure();
    logic [63:0] chips, firsts, lasts;
    int n, busy_n, stall_err, junk_acc, acc_on_last;
    run_frames(8'h80, 8'h00, 1, 1, 90, -1, -1, chips, n, firsts, lasts,
               busy_n, stall_err, junk_acc, acc_on_last);
    checks++;
    if (n !== 24) begin fails++; $display("FAIL bp_count: got %0d expected 24", n); end
    checks++;
    if (chips[23:0] !== 24'hE00000) begin
      fails++; $display("FAIL bp_chips: got %h expected e00000", chips[23:0]);
    end
    checks++;
    if (stall_err !== 0) begin fails++; $display("FAIL bp_stall_hold: got %0d violations expected 0", stall_err); end
    checks++;
    if (tx_valid !== 1'b0) begin fails++; $display("FAIL bp_end_idle: tx_valid=%b expected 0", tx_valid); end
    $display("test_backpressure: 80 chips=%h transfers=%0d", chips[23:0], n);
  endtask

  task automatic test_back_to_back();
    logic [63:0] chips, firsts, lasts;
    int n, busy_n, stall_err, junk_acc, acc_on_last;
    run_frames(8'hFF, 8'h00, 2, 0, 60, -1, -1, chips, n, firsts, lasts,
               busy_n, stall_err, junk_acc, acc_on_last);
    checks++;
    if (n !== 48) begin fails++; $display("FAIL b2b_count: got %0d expected 48", n); end
    checks++;
    if (chips[47:0] !== 48'hFFFFFF000000) begin
      fails++; $display("FAIL b2b_chips: got %h expected ffffff000000", chips[47:0]);
    end
    checks++;
    if (firsts[47:0] !== 48'h800000800000 || lasts[47:0] !== 48'h000001000001) begin
      fails++; $display("FAIL b2b_flags: first %h last %h expected 800000800000 000001000001", firsts[47:0], lasts[47:0]);
    end
    checks++;
    if (acc_on_last !== 1) begin fails++; $display("FAIL b2b_accept_on_last: got %0d expected 1", acc_on_last); end
    checks++;
    if (busy_n !== 48) begin fails++; $display("FAIL b2b_no_gap: busy cycles %0d expected 48", busy_n); end
    $display("test_back_to_back: FF,00 chips=%h", chips[47:0]);
  endtask

  task automatic test_busy_reject();
    logic [63:0] chips, firsts, lasts;
    int n, busy_n, stall_err, junk_acc, acc_on_last;
    run_frames(8'h0F, 8'h00, 1, 0, 40, 5, 15, chips, n, firsts, lasts,
               busy_n, stall_err, junk_acc, acc_on_last);
    checks++;
    if (junk_acc !== 0) begin fails++; $display("FAIL reject_accepts: got %0d expected 0", junk_acc); end
    checks++;
    if (n !== 24 || chips[23:0] !== 24'h000FFF) begin
      fails++; $display("FAIL reject_chips: got %0d chips %h expected 24 000fff", n, chips[23:0]);
    end
    checks++;
    if (busy_n !== 24) begin fails++; $display("FAIL reject_busy: got %0d expected 24", busy_n); end
    $display("test_busy_reject: 0F chips=%h rejected_accepts=%0d", chips[23:0], junk_acc);
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] chips, firsts, lasts;
    int n, busy_n, stall_err, junk_acc, acc_on_last;
    in_valid = 1'b1; in_data = 8'hA5; tx_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_in_ready_now: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if ({tx_valid, busy, tx_bit, in_ready, tx_first, tx_last} !== 6'b0) begin
      fails++; $display("FAIL rstmid_outputs: got %b expected 000000", {tx_valid, busy, tx_bit, in_ready, tx_first, tx_last});
    end
    rst = 1'b0;
    run_frames(8'h01, 8'h00, 1, 0, 32, -1, -1, chips, n, firsts, lasts,
               busy_n, stall_err, junk_acc, acc_on_last);
    checks++;
    if (n !== 24 || chips[23:0] !== 24'h000007) begin
      fails++; $display("FAIL rstmid_next_frame: got %0d chips %h expected 24 000007", n, chips[23:0]);
    end
    checks++;
    if (firsts[23:0] !== 24'h800000) begin
      fails++; $display("FAIL rstmid_first: got %h expected 800000", firsts[23:0]);
    end
    $display("test_reset_mid_frame: 01 chips=%h", chips[23:0]);
  endtask

  task automatic test_param_sweep();
    logic [19:0] chips = '0;
    logic [19:0] firsts = '0;
    logic [19:0] lasts = '0;
    logic [19:0] flipped;
    logic [3:0]  rec_clean, rec_err;
    int n = 0;
    int ones_c, ones_e;
    in_valid4 = 1'b1; in_data4 = 4'b1001; tx_ready4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (tx_valid4 && tx_ready4) begin
        chips  = {chips[18:0], tx_bit4};
        firsts = {firsts[18:0], tx_first4};
        lasts  = {lasts[18:0], tx_last4};
        n++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n !== 20) begin fails++; $display("FAIL sweep_count: got %0d expected 20", n); end
    checks++;
    if (chips !== 20'hF801F) begin fails++; $display("FAIL sweep_chips: got %h expected f801f", chips); end
    checks++;
    if (firsts !== 20'h80000 || lasts !== 20'h00001) begin
      fails++; $display("FAIL sweep_flags: first %h last %h expected 80000 00001", firsts, lasts);
    end
    // One chip corrupted in every 5-chip group, at a different position each time.
    flipped = chips;
    for (int b = 0; b < 4; b++) flipped[19 - (b * 5 + b)] = ~flipped[19 - (b * 5 + b)];
    for (int b = 0; b < 4; b++) begin
      ones_c = 0; ones_e = 0;
      for (int k = 0; k < 5; k++) begin
        ones_c += int'(chips[19 - (b * 5 + k)]);
        ones_e += int'(flipped[19 - (b * 5 + k)]);
      end
      rec_clean[3 - b] = (ones_c >= 3);
      rec_err[3 - b]   = (ones_e >= 3);
    end
    checks++;
    if (rec_clean !== 4'b1001 || rec_err !== 4'b1001) begin
      fails++; $display("FAIL sweep_majority: clean %b corrupted %b expected 1001", rec_clean, rec_err);
    end
    $display("test_param_sweep: 1001 chips=%b recovered=%b", chips, rec_err);
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid_frame();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000 expected finish");
    $fatal(1, "timeout");
  end

endmodule
